aes_ctrl: RTL
=============

Name: aes_ctrl

Overview:
Parametrised successor to the single-key AES top level. It stores up to KEY_SLOTS expanded AES-128 key schedules in one round-key SRAM and serves SET_KEY, ENCRYPT and DECRYPT commands.
- Input side: valid/ready command handshake.
- Output side: valid/ready response handshake with a status code.
- It instantiates the existing round_key and cipher blocks and a new inv_cipher block. inv_cipher has the same ports as cipher.

Parameters:
KEY_SLOTS, 4, number of stored key schedules (power of two, 1..16)
SLOT_W, 2, slot index width, equals clog2(KEY_SLOTS) with a minimum of 1
NR, 10, number of AES rounds; a schedule occupies NR+1 words

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
in_valid  in  1  command valid
in_ready  out  1  block accepts a command this cycle
in_cmd  in  WORD_S  command: `SET_KEY, `ENCRYPT or `DECRYPT (aes.vh)
in_slot  in  SLOT_W  key slot used by the command
in_key  in  KEY_S  key; used only by SET_KEY
in_blk  in  BLK_S  plaintext or ciphertext
out_valid  out  1  response valid
out_ready  in  1  consumer accepts the response
out_blk  out  BLK_S  result block; zero for SET_KEY and error responses
out_status  out  2  00 OK, 01 ERR_SLOT, 10 ERR_CMD, 11 reserved (never driven)
busy  out  1  FSM is not in IDLE
slot_loaded  out  KEY_SLOTS  per-slot "schedule valid" flags

Behaviour:
- Reset values: in_ready=0, out_valid=0, out_blk=0, out_status=00, busy=0, slot_loaded=0, FSM=IDLE.
- in_ready is 1 only in IDLE, from the first cycle after reset deasserts.
- A command is accepted when in_valid && in_ready. On acceptance, cmd, slot, key and blk are registered.
- FSM states: IDLE, KEYEXP, ENC, DEC, RESP.
- Transitions out of IDLE (on accept):
  - SET_KEY -> KEYEXP; slot_loaded[slot] clears in the same cycle.
  - ENCRYPT -> ENC, or DECRYPT -> DEC, when slot_loaded[slot]=1.
  - ENCRYPT or DECRYPT with slot_loaded[slot]=0 -> RESP with status 01.
  - Any other cmd -> RESP with status 10.
- A one-cycle pulse to the selected submodule's en starts KEYEXP/ENC/DEC. The submodule is never re-pulsed while running.
- SRAM address is {slot, word}, with depth KEY_SLOTS*16; words NR+1..15 of each slot are unused.
  - KEYEXP: word = round_key.round_no, written on w_e.
  - ENC: word = cipher.round_no.
  - DEC: word = NR - inv_cipher.round_no, so round keys are read in reverse order.
- Completion:
  - KEYEXP ends on round_key en_o: set slot_loaded[slot], -> RESP, status 00, out_blk=0.
  - ENC/DEC end on the submodule en_o: capture its output into out_blk, -> RESP, status 00.
- Latency: out_valid rises the cycle after the submodule en_o. Error responses rise the cycle after accept.
- RESP: out_valid=1 and out_blk/out_status are held stable until out_ready. On the handshake: out_valid=0 next cycle, -> IDLE.
  - in_ready returns the cycle after the response handshake. Commands never overlap.
- Back-pressure: out_ready low holds RESP indefinitely with no data change and in_ready=0.
- Re-keying a loaded slot: it is marked unloaded for the whole of KEYEXP. Other slots are unaffected.
- Reset asserted mid-operation: on the next edge, return to IDLE, clear slot_loaded (all stored schedules are invalidated), drop out_valid, and reset the submodules. SRAM contents are don't-care.
- SLOT_W indexing: with KEY_SLOTS=1, in_slot is ignored (treated as slot 0).

Test Plan:
1. Reset, then SET_KEY slot 2, key 000102030405060708090a0b0c0d0e0f -> one response {status 00, out_blk 0}; slot_loaded=0100b.
2. Then ENCRYPT slot 2, blk 00112233445566778899aabbccddeeff -> out_blk 69c4e0d86a7b0430d8cdb78070b4c55a, status 00.
3. DECRYPT slot 2, blk 69c4e0d86a7b0430d8cdb78070b4c55a -> out_blk 00112233445566778899aabbccddeeff; ENCRYPT slot 1 (unloaded) -> status 01, out_blk 0, response the cycle after accept.
4. Hold out_ready=0 for 20 cycles after an encrypt completes -> out_valid, out_blk and out_status are stable and in_ready=0 throughout; a single transfer occurs when out_ready=1.
5. Load slots 0 and 3 with different keys and interleave ENCRYPTs -> each result matches its own key's reference; an undefined in_cmd -> status 10.
6. Assert reset during ENC -> the next cycle out_valid=0, slot_loaded=0 and busy=0; a following ENCRYPT on any slot -> status 01.

Source files
------------

// File: rtl/aes_ctrl.sv
// ------------------------------------------------------------------------------
// aes_ctrl: multi-slot AES-128 command controller with round-key SRAM. Rev 1.0
// ------------------------------------------------------------------------------
`default_nettype none

package aes_ctrl_pkg;
    localparam int WORD_S = 32;
    localparam int KEY_S  = 128;
    localparam int BLK_S  = 128;

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // Multiplicative inverse as a^254 (maps 0 to 0), avoiding a 256-entry table.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 0; i < 7; i++) begin
            sq  = gmul(sq, sq);
            acc = gmul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        return ginv({s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] x, input logic inv);
        logic [127:0] y;
        y = '0;
        for (int i = 0; i < 16; i++)
            y[127-8*i -: 8] = inv ? inv_sbox(x[127-8*i -: 8]) : sbox(x[127-8*i -: 8]);
        return y;
    endfunction

    // Byte 4*c+r holds row r of column c; byte 0 is the most significant.
    function automatic logic [127:0] shift_rows(input logic [127:0] x, input logic inv);
        logic [127:0] y;
        y = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                y[127-8*(4*c+r) -: 8] = inv ? x[127-8*(4*((c+4-r)%4)+r) -: 8]
                                            : x[127-8*(4*((c+r)%4)+r) -: 8];
        return y;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] x, input logic inv);
        logic [127:0] y;
        logic [7:0]   a [4];
        y = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) a[r] = x[127-8*(4*c+r) -: 8];
            for (int r = 0; r < 4; r++)
                y[127-8*(4*c+r) -: 8] = inv ?
                    (gmul(a[r], 8'h0e) ^ gmul(a[(r+1)%4], 8'h0b) ^
                     gmul(a[(r+2)%4], 8'h0d) ^ gmul(a[(r+3)%4], 8'h09)) :
                    (gmul(a[r], 8'h02) ^ gmul(a[(r+1)%4], 8'h03) ^ a[(r+2)%4] ^ a[(r+3)%4]);
        end
        return y;
    endfunction
endpackage

module round_key #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [127:0] key,
    output logic [3:0]   round_no,
    output logic         w_e,
    output logic [127:0] rk,
    output logic         en_o
);
    import aes_ctrl_pkg::*;
    localparam logic [3:0] LAST = 4'(NR);

    logic [127:0] cur;
    logic [127:0] nxt;
    logic [7:0]   rcon;
    logic [31:0]  t;
    logic         run;

    always_comb begin
        t           = sub_word({cur[23:0], cur[31:24]}) ^ {rcon, 24'h0};
        nxt[127:96] = cur[127:96] ^ t;
        nxt[95:64]  = cur[95:64]  ^ nxt[127:96];
        nxt[63:32]  = cur[63:32]  ^ nxt[95:64];
        nxt[31:0]   = cur[31:0]   ^ nxt[63:32];
    end

    always_ff @(posedge clk) begin
        en_o <= 1'b0;
        if (reset) begin
            cur      <= '0;
            rcon     <= 8'h00;
            round_no <= 4'd0;
            run      <= 1'b0;
        end else if (en && !run) begin
            cur      <= key;
            rcon     <= 8'h01;
            round_no <= 4'd0;
            run      <= 1'b1;
        end else if (run) begin
            if (round_no == LAST) begin
                run      <= 1'b0;
                round_no <= 4'd0;
                en_o     <= 1'b1;
            end else begin
                cur      <= nxt;
                rcon     <= xtime(rcon);
                round_no <= round_no + 4'd1;
            end
        end
    end

    assign w_e = run;
    assign rk  = cur;
endmodule

// Shared datapath skeleton for cipher / inv_cipher; INV selects the inverse rounds.
module aes_rounds #(
    parameter int NR  = 10,
    parameter bit INV = 1'b0
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [127:0] blk,
    input  logic [127:0] rk,
    output logic [3:0]   round_no,
    output logic [127:0] result,
    output logic         en_o
);
    import aes_ctrl_pkg::*;
    localparam logic [3:0] LAST = 4'(NR);

    logic [127:0] st;
    logic [127:0] fwd;
    logic [127:0] inv_t;
    logic         run;

    assign fwd   = shift_rows(sub_bytes(st, 1'b0), 1'b0);
    assign inv_t = sub_bytes(shift_rows(st, 1'b1), 1'b1) ^ rk;

    always_ff @(posedge clk) begin
        en_o <= 1'b0;
        if (reset) begin
            st       <= '0;
            round_no <= 4'd0;
            run      <= 1'b0;
        end else if (en && !run) begin
            st       <= blk ^ rk;
            round_no <= 4'd1;
            run      <= 1'b1;
        end else if (run) begin
            if (round_no == LAST) begin
                st       <= INV ? inv_t : (fwd ^ rk);
                run      <= 1'b0;
                round_no <= 4'd0;
                en_o     <= 1'b1;
            end else begin
                st       <= INV ? mix_columns(inv_t, 1'b1) : (mix_columns(fwd, 1'b0) ^ rk);
                round_no <= round_no + 4'd1;
            end
        end
    end

    assign result = st;
endmodule

module cipher #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [127:0] blk,
    input  logic [127:0] rk,
    output logic [3:0]   round_no,
    output logic [127:0] result,
    output logic         en_o
);
    aes_rounds #(.NR(NR), .INV(1'b0)) u_core (
        .clk(clk), .reset(reset), .en(en), .blk(blk), .rk(rk),
        .round_no(round_no), .result(result), .en_o(en_o)
    );
endmodule

module inv_cipher #(
    parameter int NR = 10
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         en,
    input  logic [127:0] blk,
    input  logic [127:0] rk,
    output logic [3:0]   round_no,
    output logic [127:0] result,
    output logic         en_o
);
    aes_rounds #(.NR(NR), .INV(1'b1)) u_core (
        .clk(clk), .reset(reset), .en(en), .blk(blk), .rk(rk),
        .round_no(round_no), .result(result), .en_o(en_o)
    );
endmodule

module aes_ctrl #(
    parameter int          KEY_SLOTS   = 4,
    parameter int          SLOT_W      = 2,
    parameter int          NR          = 10,
    parameter logic [31:0] CMD_SET_KEY = 32'h1,
    parameter logic [31:0] CMD_ENCRYPT = 32'h2,
    parameter logic [31:0] CMD_DECRYPT = 32'h3
) (
    input  logic                             clk,
    input  logic                             reset,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [aes_ctrl_pkg::WORD_S-1:0]  in_cmd,
    input  logic [SLOT_W-1:0]                in_slot,
    input  logic [aes_ctrl_pkg::KEY_S-1:0]   in_key,
    input  logic [aes_ctrl_pkg::BLK_S-1:0]   in_blk,
    output logic                             out_valid,
    input  logic                             out_ready,
    output logic [aes_ctrl_pkg::BLK_S-1:0]   out_blk,
    output logic [1:0]                       out_status,
    output logic                             busy,
    output logic [KEY_SLOTS-1:0]             slot_loaded
);
    localparam logic [SLOT_W-1:0] SLOT_MASK = SLOT_W'(KEY_SLOTS - 1);
    localparam logic [3:0]        LAST      = 4'(NR);
    localparam logic [1:0]        ST_OK     = 2'b00;
    localparam logic [1:0]        ST_SLOT   = 2'b01;
    localparam logic [1:0]        ST_CMD    = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_KEYEXP = 3'd1,
        S_ENC    = 3'd2,
        S_DEC    = 3'd3,
        S_RESP   = 3'd4
    } state_t;

    state_t              state;
    logic [SLOT_W-1:0]   slot_r;
    logic [SLOT_W-1:0]   in_slot_m;
    logic [127:0]        key_r;
    logic [127:0]        blk_r;
    logic                key_go;
    logic                enc_go;
    logic                dec_go;
    logic [3:0]          kr_round;
    logic [3:0]          enc_round;
    logic [3:0]          dec_round;
    logic                kr_we;
    logic                kr_done;
    logic                enc_done;
    logic                dec_done;
    logic [127:0]        kr_rk;
    logic [127:0]        enc_res;
    logic [127:0]        dec_res;
    logic [3:0]          word;
    logic [SLOT_W+3:0]   sram_addr;
    logic [127:0]        rk_word;
    logic [127:0]        sram [KEY_SLOTS*16];

    assign in_slot_m = in_slot & SLOT_MASK;

    // Decryption walks the schedule backwards: round n uses word NR-n.
    always_comb begin
        word = 4'd0;
        case (state)
            S_KEYEXP: word = kr_round;
            S_ENC:    word = enc_round;
            S_DEC:    word = LAST - dec_round;
            default:  word = 4'd0;
        endcase
    end

    assign sram_addr = {slot_r, word};
    assign rk_word   = sram[sram_addr];

    always_ff @(posedge clk) begin
        if (kr_we && state == S_KEYEXP) sram[sram_addr] <= kr_rk;
    end

    round_key #(.NR(NR)) u_round_key (
        .clk(clk), .reset(reset), .en(key_go), .key(key_r),
        .round_no(kr_round), .w_e(kr_we), .rk(kr_rk), .en_o(kr_done)
    );

    cipher #(.NR(NR)) u_cipher (
        .clk(clk), .reset(reset), .en(enc_go), .blk(blk_r), .rk(rk_word),
        .round_no(enc_round), .result(enc_res), .en_o(enc_done)
    );

    inv_cipher #(.NR(NR)) u_inv_cipher (
        .clk(clk), .reset(reset), .en(dec_go), .blk(blk_r), .rk(rk_word),
        .round_no(dec_round), .result(dec_res), .en_o(dec_done)
    );

    always_ff @(posedge clk) begin
        key_go <= 1'b0;
        enc_go <= 1'b0;
        dec_go <= 1'b0;
        if (reset) begin
            state       <= S_IDLE;
            slot_r      <= '0;
            key_r       <= '0;
            blk_r       <= '0;
            in_ready    <= 1'b0;
            out_valid   <= 1'b0;
            out_blk     <= '0;
            out_status  <= ST_OK;
            busy        <= 1'b0;
            slot_loaded <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        slot_r   <= in_slot_m;
                        key_r    <= in_key;
                        blk_r    <= in_blk;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                        if (in_cmd == CMD_SET_KEY) begin
                            slot_loaded[in_slot_m] <= 1'b0;
                            key_go <= 1'b1;
                            state  <= S_KEYEXP;
                        end else if (in_cmd == CMD_ENCRYPT || in_cmd == CMD_DECRYPT) begin
                            if (slot_loaded[in_slot_m]) begin
                                enc_go <= (in_cmd == CMD_ENCRYPT);
                                dec_go <= (in_cmd == CMD_DECRYPT);
                                state  <= (in_cmd == CMD_ENCRYPT) ? S_ENC : S_DEC;
                            end else begin
                                out_blk    <= '0;
                                out_status <= ST_SLOT;
                                out_valid  <= 1'b1;
                                state      <= S_RESP;
                            end
                        end else begin
                            out_blk    <= '0;
                            out_status <= ST_CMD;
                            out_valid  <= 1'b1;
                            state      <= S_RESP;
                        end
                    end
                end
                S_KEYEXP: begin
                    if (kr_done) begin
                        slot_loaded[slot_r] <= 1'b1;
                        out_blk    <= '0;
                        out_status <= ST_OK;
                        out_valid  <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_ENC: begin
                    if (enc_done) begin
                        out_blk    <= enc_res;
                        out_status <= ST_OK;
                        out_valid  <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_DEC: begin
                    if (dec_done) begin
                        out_blk    <= dec_res;
                        out_status <= ST_OK;
                        out_valid  <= 1'b1;
                        state      <= S_RESP;
                    end
                end
                S_RESP: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

`default_nettype wire
